// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage datapath combining a single-cycle ALU with a
// multi-cycle multiply/divide unit that owns the HI/LO registers.
module alu_mdu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] C,
  input  logic [2:0]       mdu_op,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW    = $clog2(WIDTH);
  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned MAXC   = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MAXC + 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [SHW-1:0]     shamt;
  logic               is_signed;
  logic               is_mul;
  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   uquo;
  logic [WIDTH-1:0]   urem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign shamt = B[SHW-1:0];

  // Combinational ALU; independent of the MDU state.
  always_comb begin
    C = '0;
    case (alu_op)
      ALU_ADD:  C = A + B;
      ALU_SUB:  C = A - B;
      ALU_OR:   C = A | B;
      ALU_LUI:  C = {B[HALF-1:0], {HALF{1'b0}}};
      ALU_AND:  C = A & B;
      ALU_XOR:  C = A ^ B;
      ALU_NOR:  C = ~(A | B);
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:  C = A << shamt;
      ALU_SRL:  C = A >> shamt;
      ALU_SRA:  C = $signed(A) >>> shamt;
      default:  C = '0;
    endcase
  end

  // MDU datapath evaluated from the operands latched at start.
  assign is_signed = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign is_mul    = (op_q == MDU_MULT) || (op_q == MDU_MULTU);
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  // Sign-extending to 2*WIDTH makes one unsigned multiplier serve both forms.
  assign prod      = {{WIDTH{a_neg}}, a_q} * {{WIDTH{b_neg}}, b_q};
  assign abs_a     = a_neg ? -a_q : a_q;
  assign abs_b     = b_neg ? -b_q : b_q;
  // Divide-by-zero never writes back, so a dummy divisor keeps the divider defined.
  assign div_b     = (abs_b == '0) ? WIDTH'(1) : abs_b;
  assign uquo      = abs_a / div_b;
  assign urem      = abs_a % div_b;
  // MIN / -1 falls out naturally: the magnitude quotient wraps back to MIN.
  assign quo       = (a_neg ^ b_neg) ? -uquo : uquo;
  assign rem       = a_neg ? -urem : urem;

  // MDU next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdu_op)
            MDU_MULT, MDU_MULTU: begin
              op_d    = mdu_op;
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(MUL_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              op_d    = mdu_op;
              a_d     = A;
              b_d     = B;
              cnt_d   = CNT_W'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            MDU_MTHI: hi_d = A;
            MDU_MTLO: lo_d = A;
            default:  ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (is_mul) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MDU state registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: driver pushes expected MDU results, a
// negedge monitor pops and compares them when busy drops.
module tb_alu_mdu;

  logic        clk;
  logic        reset_n;
  logic [31:0] A, B, C;
  logic [3:0]  alu_op;
  logic [2:0]  mdu_op;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  logic [15:0] A16, B16, C16, hi16, lo16;
  logic [3:0]  alu_op16;
  logic [2:0]  mdu_op16;
  logic        start16;
  logic        busy16;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .alu_op(alu_op), .C(C),
    .mdu_op(mdu_op), .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .A(A16), .B(B16), .alu_op(alu_op16), .C(C16),
    .mdu_op(mdu_op16), .start(start16), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  int          mon_cnt = 0;
  logic        mon_prev = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference ALU from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa = $signed(a);
    int          sb = $signed(b);
    int unsigned sh = int'(b[4:0]);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return b << 16;
      4'd4:    return a & b;
      4'd5:    return a ^ b;
      4'd6:    return ~(a | b);
      4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return a << sh;
      4'd10:   return a >> sh;
      4'd11:   return sa >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  // Reference MDU using 64-bit integer arithmetic.
  function automatic exp_t ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    exp_t            e;
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          p;
    longint          q;
    longint          r;
    longint unsigned up;
    e.hi = cur_hi;
    e.lo = cur_lo;
    e.cycles = 10;
    case (op)
      3'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = 5; e.name = "MULT"; end
      3'd2: begin up = ua * ub; e.hi = up[63:32]; e.lo = up[31:0]; e.cycles = 5; e.name = "MULTU"; end
      3'd3: begin
        e.name = "DIV";
        if (b != 0) begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      default: begin
        e.name = "DIVU";
        if (b != 0) begin up = ua / ub; e.lo = up[31:0]; up = ua % ub; e.hi = up[31:0]; end
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: hi/lo must hold while busy, and match the scoreboard when busy drops.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_cnt  = 0;
        mon_prev = 1'b0;
      end else begin
        if (busy) begin
          mon_cnt++;
          chk("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
        end else if (mon_prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: busy dropped with empty scoreboard, hi 0x%0h lo 0x%0h", hi, lo);
          end else begin
            mon_e = sb_q.pop_front();
            chk({mon_e.name, "_busy_cycles"}, 64'(mon_cnt), 64'(mon_e.cycles));
            chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
            chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
            exp_hi = mon_e.hi;
            exp_lo = mon_e.lo;
          end
          mon_cnt = 0;
        end
        mon_prev = busy;
      end
    end
  end

  task automatic alu_lit(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] req);
    alu_op = op; A = a; B = b;
    #1 chk(name, 64'(C), 64'(req));
  endtask

  task automatic alu_rand();
    alu_op = 4'($urandom_range(0, 15)); A = pick(); B = pick();
    #1 chk("alu_random", 64'(C), 64'(ref_alu(alu_op, A, B)));
  endtask

  // MTHI/MTLO or a no-op start while idle.
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #1;
    mdu_op = op; A = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    if (op == 3'd5) exp_hi = a;
    if (op == 3'd6) exp_lo = a;
    chk("mt_busy", 64'(busy), 64'd0);
    chk("mt_hilo", {hi, lo}, {exp_hi, exp_lo});
  endtask

  // Issue a multiply/divide and wait for it, optionally disturbing inputs while busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit disturb, input int mtlo_cycle);
    bit done = 1'b0;
    @(posedge clk); #1;
    A = a; B = b; mdu_op = op; start = 1'b1;
    sb_q.push_back(ref_mdu(op, a, b, exp_hi, exp_lo));
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (disturb) begin
        A = $urandom; B = $urandom;
        start = 1'($urandom_range(0, 1));
        mdu_op = 3'($urandom_range(0, 7));
        alu_op = 4'($urandom_range(0, 15));
        #1 chk("alu_during_busy", 64'(C), 64'(ref_alu(alu_op, A, B)));
      end
      if (i == mtlo_cycle) begin
        mdu_op = 3'd6; A = 32'h1234; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; mdu_op = 3'd0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy still %0b after 40 cycles", busy);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b1;
    A = '0; B = '0; alu_op = '0; mdu_op = '0; start = 1'b0;
    A16 = '0; B16 = '0; alu_op16 = '0; mdu_op16 = '0; start16 = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy16", 64'(busy16), 64'd0);
    @(posedge clk); #2 reset_n = 1'b1;

    // Combinational sweep.
    alu_lit("ADD", 4'd0, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF);
    alu_lit("OR", 4'd2, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF);
    alu_lit("AND", 4'd4, 32'hFFFF0000, 32'h0000FFFF, 32'h0);
    alu_lit("LUI", 4'd3, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000);
    alu_lit("SRA", 4'd11, 32'h80000000, 32'd4, 32'hF8000000);
    alu_lit("SRL", 4'd10, 32'h80000000, 32'd4, 32'h08000000);
    alu_lit("SLT", 4'd7, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_lit("SLTU", 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0);
    alu_lit("SUB_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFFFFFF);
    alu_lit("op15", 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    for (int i = 0; i < 20; i++) alu_rand();

    // Directed MDU cases.
    issue(3'd1, 32'hFFFFFFFD, 32'd7, 1'b0, -1);
    chk("MULT_-3x7", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    chk("MULTU_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
    chk("DIV_-7/2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    mt(3'd5, 32'h11);
    mt(3'd6, 32'h22);
    issue(3'd4, 32'd7, 32'd0, 1'b0, -1);
    chk("DIVU_by0", {hi, lo}, 64'h00000011_00000022);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
    chk("DIV_min_neg1", {hi, lo}, 64'h00000000_80000000);
    mt(3'd0, 32'hAAAA5555);
    mt(3'd7, 32'h5555AAAA);
    issue(3'd1, 32'h00012345, 32'hFFFF0F0F, 1'b1, 1);

    // Randomised mix.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: issue(3'($urandom_range(1, 4)), pick(), pick(), 1'($urandom_range(0, 1)), -1);
        4:          mt(3'($urandom_range(5, 6)), $urandom);
        default:    alu_rand();
      endcase
    end

    // Asynchronous reset in the middle of a divide.
    mt(3'd5, 32'hDEAD0001);
    mt(3'd6, 32'hBEEF0002);
    @(posedge clk); #1;
    A = 32'hFFFFFF00; B = 32'd3; mdu_op = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 3'd0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_writeback", {63'd0, busy}, 64'd0);
    chk("abort_hilo_zero", {hi, lo}, 64'd0);
    issue(3'd1, 32'd2, 32'd3, 1'b0, -1);
    chk("MULT_after_reset", {hi, lo}, 64'h00000000_00000006);

    // Narrow instance: WIDTH=16, single-cycle multiply.
    @(posedge clk); #1;
    alu_op16 = 4'd3; A16 = 16'h1234; B16 = 16'h00AB;
    #1 chk("LUI16", 64'(C16), 64'hAB00);
    alu_op16 = 4'd11; A16 = 16'h8000; B16 = 16'h0004;
    #1 chk("SRA16", 64'(C16), 64'hF800);
    @(posedge clk); #1;
    A16 = 16'h7FFF; B16 = 16'h7FFF; mdu_op16 = 3'd1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; mdu_op16 = 3'd0;
    chk("busy16_cycle1", 64'(busy16), 64'd1);
    chk("hold16", {32'd0, hi16, lo16}, 64'd0);
    @(posedge clk); #1;
    chk("busy16_done", 64'(busy16), 64'd0);
    chk("MULT16", {32'd0, hi16, lo16}, 64'h3FFF_0001);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
